fpu_issue_ctrl: RTL

- Sits in the ID stage of the RV32IF core, between instruction decode and the FPU.
- Classifies the instruction in ID and tracks pending FPU writes to f- and x-registers in a scoreboard.
- Stalls ID on RAW/WAW hazards and on FPU occupancy; issues OP-FP instructions to the FPU over a valid/ready handshake.
- Drains all outstanding FPU work before any fflags/frm/fcsr CSR access.

---
 rtl/fpu_issue_pkg.sv | 49 ++++
 rtl/fpu_issue_ctrl_scoreboard.sv | 76 +++++++
 rtl/fpu_issue_ctrl.sv | 151 +++++++++++++++
 3 files changed

// File: rtl/fpu_issue_pkg.sv
// Shared decode constants, FSM state type and FPU request record for fpu_issue_ctrl.
package fpu_issue_pkg;

  localparam logic [4:0] OPC_OP_FP    = 5'b10100;
  localparam logic [4:0] OPC_LOAD_FP  = 5'b00001;
  localparam logic [4:0] OPC_STORE_FP = 5'b01001;
  localparam logic [4:0] OPC_SYSTEM   = 5'b11100;

  localparam logic [4:0] F5_FADD     = 5'b00000;
  localparam logic [4:0] F5_FSUB     = 5'b00001;
  localparam logic [4:0] F5_FMUL     = 5'b00010;
  localparam logic [4:0] F5_FDIV     = 5'b00011;
  localparam logic [4:0] F5_FSGNJ    = 5'b00100;
  localparam logic [4:0] F5_FMINMAX  = 5'b00101;
  localparam logic [4:0] F5_FCMP     = 5'b10100;
  localparam logic [4:0] F5_FCVT_W_S = 5'b11000;
  localparam logic [4:0] F5_FMV_X_W  = 5'b11100;
  localparam logic [4:0] F5_FCVT_S_W = 5'b11010;
  localparam logic [4:0] F5_FMV_W_X  = 5'b11110;

  localparam logic [11:0] CSR_FFLAGS = 12'h001;
  localparam logic [11:0] CSR_FRM    = 12'h002;
  localparam logic [11:0] CSR_FCSR   = 12'h003;

  typedef enum logic [1:0] {RUN, ISSUE, DRAIN} state_t;

  typedef struct packed {
    logic [4:0] op;
    logic [2:0] rm;
    logic [1:0] fmt;
    logic [4:0] rs2;
    logic [4:0] rd;
    logic       xdst;
  } fpu_req_t;

  function automatic logic f5_xdst(input logic [4:0] f5);
    return (f5 == F5_FCMP) || (f5 == F5_FCVT_W_S) || (f5 == F5_FMV_X_W);
  endfunction

  function automatic logic f5_rs1_x(input logic [4:0] f5);
    return (f5 == F5_FCVT_S_W) || (f5 == F5_FMV_W_X);
  endfunction

  function automatic logic f5_uses_rs2(input logic [4:0] f5);
    return (f5 == F5_FADD) || (f5 == F5_FSUB) || (f5 == F5_FMUL) || (f5 == F5_FDIV) ||
           (f5 == F5_FSGNJ) || (f5 == F5_FMINMAX) || (f5 == F5_FCMP);
  endfunction

endpackage

// File: rtl/fpu_issue_ctrl_scoreboard.sv
// Pending-write scoreboard for the f- and x-register files, with hazard queries and sb_err.
// FPU_SB_BYPASS_EN: hide the register being written back this cycle from the hazard queries.
module fpu_scoreboard (
  input  logic       clk,
  input  logic       rst_n,
  input  logic       set_en,
  input  logic [4:0] set_rd,
  input  logic       set_x,
  input  logic       clr_en,
  input  logic [4:0] clr_rd,
  input  logic       clr_x,
  input  logic [4:0] rs1,
  input  logic       rs1_x,
  input  logic       rs1_use,
  input  logic [4:0] rs2,
  input  logic       rs2_x,
  input  logic       rs2_use,
  input  logic [4:0] rd,
  input  logic       rd_x,
  input  logic       rd_use,
  output logic       rs1_busy,
  output logic       rs2_busy,
  output logic       rd_busy,
  output logic       sb_err
);
  logic [31:0] f_pend, x_pend;
  logic [31:0] f_set, x_set, f_clr, x_clr;
  logic [31:0] f_vis, x_vis;
  logic        clr_pend, spurious;

  always_comb begin
    f_set = '0;
    x_set = '0;
    f_clr = '0;
    x_clr = '0;
    if (set_en) begin
      if (set_x) x_set[set_rd] = 1'b1;
      else       f_set[set_rd] = 1'b1;
    end
    x_set[0] = 1'b0;
    if (clr_en) begin
      if (clr_x) x_clr[clr_rd] = 1'b1;
      else       f_clr[clr_rd] = 1'b1;
    end
  end

`ifdef FPU_SB_BYPASS_EN
  // write-through register file: the value being written back is already visible to ID
  assign f_vis = f_pend & ~f_clr;
  assign x_vis = x_pend & ~x_clr;
`else
  assign f_vis = f_pend;
  assign x_vis = x_pend;
`endif

  assign rs1_busy = rs1_use & (rs1_x ? x_vis[rs1] : f_vis[rs1]);
  assign rs2_busy = rs2_use & (rs2_x ? x_vis[rs2] : f_vis[rs2]);
  assign rd_busy  = rd_use  & (rd_x  ? x_vis[rd]  : f_vis[rd]);

  assign clr_pend = clr_x ? x_pend[clr_rd] : f_pend[clr_rd];
  assign spurious = clr_en & ~(clr_x & (clr_rd == 5'd0)) & ~clr_pend;

  // set is OR-ed after the clear so a same-cycle set of the same bit wins
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      f_pend <= '0;
      x_pend <= '0;
      sb_err <= 1'b0;
    end else begin
      f_pend <= (f_pend & ~f_clr) | f_set;
      x_pend <= (x_pend & ~x_clr) | x_set;
      sb_err <= sb_err | spurious;
    end
  end

endmodule

// File: rtl/fpu_issue_ctrl.sv
// ID-stage FPU issue control: classifies the ID instruction, stalls on hazards/occupancy, issues OP-FP.
// States: RUN accept or stall | ISSUE hold request until ready | DRAIN wait for out_cnt==0. Option: FPU_SB_BYPASS_EN.
module fpu_issue_ctrl
  import fpu_issue_pkg::*;
#(
  parameter int MAX_OUT = 4
) (
  input  logic        clk,
  input  logic        rst_n,
  input  logic        id_valid,
  input  logic [31:0] id_inst,
  input  logic        id_flush,
  output logic        id_stall,
  output logic        fpu_req_valid,
  input  logic        fpu_req_ready,
  output logic [4:0]  fpu_req_op,
  output logic [2:0]  fpu_req_rm,
  output logic [1:0]  fpu_req_fmt,
  output logic [4:0]  fpu_req_rs2,
  output logic [4:0]  fpu_req_rd,
  output logic        fpu_req_xdst,
  input  logic        fpu_resp_valid,
  input  logic [4:0]  fpu_resp_rd,
  input  logic        fpu_resp_xdst,
  output logic        sb_err
);
  state_t     state;
  fpu_req_t   req;
  logic [3:0] out_cnt;

  logic [4:0]  opc, f5, rd, rs1, rs2;
  logic [2:0]  func3;
  logic [11:0] csr;
  logic        is_32b, is_opfp, is_load, is_store, is_fcsr;
  logic        rs1_x, rs1_use, rs2_x, rs2_use, rd_x, rd_use;
  logic        rs1_busy, rs2_busy, rd_busy, hazard;
  logic        live, at_cap, need_drain, run_stall, accept_op;
  logic        handshake, resp_dec;

  assign opc   = id_inst[6:2];
  assign f5    = id_inst[31:27];
  assign rd    = id_inst[11:7];
  assign rs1   = id_inst[19:15];
  assign rs2   = id_inst[24:20];
  assign func3 = id_inst[14:12];
  assign csr   = id_inst[31:20];

  assign is_32b   = (id_inst[1:0] == 2'b11);
  assign is_opfp  = is_32b & (opc == OPC_OP_FP);
  assign is_load  = is_32b & (opc == OPC_LOAD_FP);
  assign is_store = is_32b & (opc == OPC_STORE_FP);
  assign is_fcsr  = is_32b & (opc == OPC_SYSTEM) & (func3 != 3'b000) &
                    ((csr == CSR_FFLAGS) | (csr == CSR_FRM) | (csr == CSR_FCSR));

  // non-FP opcodes check both x sources unconditionally; a false stall is harmless
  always_comb begin
    rs1_x   = 1'b1;
    rs1_use = 1'b1;
    rs2_x   = 1'b1;
    rs2_use = 1'b1;
    rd_x    = 1'b0;
    rd_use  = 1'b0;
    if (is_opfp) begin
      rs1_x   = f5_rs1_x(f5);
      rs2_x   = 1'b0;
      rs2_use = f5_uses_rs2(f5);
      rd_x    = f5_xdst(f5);
      rd_use  = 1'b1;
    end else if (is_load) begin
      rs2_use = 1'b0;
      rd_use  = 1'b1;
    end else if (is_store) begin
      rs2_x   = 1'b0;
    end
  end

  fpu_scoreboard u_sb (
    .clk      (clk),
    .rst_n    (rst_n),
    .set_en   (accept_op),
    .set_rd   (rd),
    .set_x    (rd_x),
    .clr_en   (fpu_resp_valid),
    .clr_rd   (fpu_resp_rd),
    .clr_x    (fpu_resp_xdst),
    .rs1      (rs1),
    .rs1_x    (rs1_x),
    .rs1_use  (rs1_use),
    .rs2      (rs2),
    .rs2_x    (rs2_x),
    .rs2_use  (rs2_use),
    .rd       (rd),
    .rd_x     (rd_x),
    .rd_use   (rd_use),
    .rs1_busy (rs1_busy),
    .rs2_busy (rs2_busy),
    .rd_busy  (rd_busy),
    .sb_err   (sb_err)
  );

  assign hazard     = rs1_busy | rs2_busy | rd_busy;
  assign live       = id_valid & ~id_flush;
  assign at_cap     = is_opfp & (out_cnt == 4'(MAX_OUT));
  assign need_drain = is_fcsr & (out_cnt != 4'd0);
  assign run_stall  = live & (hazard | at_cap | need_drain);
  assign accept_op  = (state == RUN) & live & ~run_stall & is_opfp;
  assign id_stall   = (state == RUN) ? run_stall : 1'b1;

  assign handshake = fpu_req_valid & fpu_req_ready;
  assign resp_dec  = fpu_resp_valid & (out_cnt != 4'd0);

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state         <= RUN;
      req           <= '0;
      fpu_req_valid <= 1'b0;
      out_cnt       <= 4'd0;
    end else begin
      out_cnt <= out_cnt + 4'(handshake) - 4'(resp_dec);
      case (state)
        RUN: begin
          if (accept_op) begin
            req           <= '{op: f5, rm: func3, fmt: id_inst[26:25], rs2: rs2, rd: rd, xdst: rd_x};
            fpu_req_valid <= 1'b1;
            state         <= ISSUE;
          end else if (live & need_drain) begin
            state <= DRAIN;
          end
        end
        ISSUE: begin
          if (fpu_req_ready) begin
            fpu_req_valid <= 1'b0;
            state         <= RUN;
          end
        end
        DRAIN: begin
          if (out_cnt == 4'd0) state <= RUN;
        end
        default: state <= RUN;
      endcase
    end
  end

  assign fpu_req_op   = req.op;
  assign fpu_req_rm   = req.rm;
  assign fpu_req_fmt  = req.fmt;
  assign fpu_req_rs2  = req.rs2;
  assign fpu_req_rd   = req.rd;
  assign fpu_req_xdst = req.xdst;

endmodule
